seg7_scan_multi: RTL and testbench

- Parametrised multiplexed 7-segment scan driver; next generation of the team's fixed 6-digit hex display scanner.
- Adds configurable digit count and scan rate, per-digit decimal point and blanking, PWM brightness, an anti-ghost guard band, and frame-coherent input snapshotting.
- Sits between the application's hex-data registers and the board's digit-select decoder and segment pins.

---
 rtl/seg7_scan_multi_if.sv | 20 ++
 rtl/seg7_scan_multi.sv | 117 +++++++++++
 tb/tb_seg7_scan_multi.sv | 135 +++++++++++++
 3 files changed

// File: rtl/seg7_scan_multi_if.sv
// Application-side bundle for the multiplexed 7-segment scanner: digit data in, scan drive out.
// The master drives the digit data; the slave (the scanner) drives sel/seg/frame_start.
interface seg7_scan_multi_if #(
  parameter int DIGITS   = 6,
  parameter int BRIGHT_W = 4,
  parameter int SEL_W    = $clog2(DIGITS)
);
  logic [4*DIGITS-1:0] data_in;
  logic [DIGITS-1:0]   dp_in;
  logic [DIGITS-1:0]   blank_in;
  logic [BRIGHT_W-1:0] brightness;
  logic [SEL_W-1:0]    sel;
  logic [7:0]          seg;
  logic                frame_start;

  modport master (output data_in, dp_in, blank_in, brightness,
                  input  sel, seg, frame_start);
  modport slave  (input  data_in, dp_in, blank_in, brightness,
                  output sel, seg, frame_start);
endinterface

// File: rtl/seg7_scan_multi.sv
// Parametrised multiplexed 7-segment scan driver with guard band, PWM brightness and frame snapshots.
// Optional leading-zero suppression is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan_multi #(
  parameter int DIGITS   = 6,
  parameter int CLK_HZ   = 50_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int BRIGHT_W = 4,
  parameter int GUARD    = 2
) (
  input  logic               clk,
  input  logic               rst,
  seg7_scan_multi_if.slave   bus
);
  localparam int TICK_DIV = CLK_HZ / SCAN_HZ;
  localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SEL_W    = $clog2(DIGITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_C  = CNT_W'(GUARD);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(DIGITS - 1);

  logic [CNT_W-1:0]    cnt;
  logic [SEL_W-1:0]    idx;
  logic [4*DIGITS-1:0] data_snap;
  logic [DIGITS-1:0]   dp_snap;
  logic [DIGITS-1:0]   blank_snap;
  logic [BRIGHT_W-1:0] bright_snap;

  logic [DIGITS-1:0]   sup_mask;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_blank;
  logic                pwm_on;
  logic                lit;
  logic                frame_edge;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h40;  4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;  4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;  4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;  4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;  4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;  4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;  4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;  default: decode = 7'h0E;
    endcase
  endfunction

`ifdef SEG7_LZ_BLANK_EN
  // Suppression runs from digit 0 and stops at the first nonzero or dp digit; the last digit always shows.
  always_comb begin
    logic run;
    run      = 1'b1;
    sup_mask = '0;
    for (int k = 0; k < DIGITS - 1; k++) begin
      run         = run && (data_snap[4*(DIGITS-1-k) +: 4] == 4'h0) && !dp_snap[k];
      sup_mask[k] = run;
    end
  end
`else
  assign sup_mask = '0;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it holding a value (latch).
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == SEL_W'(k)) begin
        cur_nib   = data_snap[4*(DIGITS-1-k) +: 4];
        cur_dp    = dp_snap[k];
        cur_blank = blank_snap[k] | sup_mask[k];
      end
    end
  end

  assign frame_edge = (cnt == '0) && (idx == '0);
  assign pwm_on     = (&bright_snap) || (cnt[BRIGHT_W-1:0] < bright_snap);
  assign lit        = (cnt >= GUARD_C) && !cur_blank && pwm_on;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt             <= '0;
      idx             <= '0;
      // NOTE: snapshot registers are few flops, not a RAM, so they are reset to a known frame.
      data_snap       <= '0;
      dp_snap         <= '0;
      blank_snap      <= '0;
      bright_snap     <= '0;
      bus.sel         <= '0;
      bus.seg         <= 8'hFF;
      bus.frame_start <= 1'b0;
    end else begin
      bus.frame_start <= frame_edge;
      bus.sel         <= idx;
      bus.seg         <= lit ? {~cur_dp, decode(cur_nib)} : 8'hFF;

      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // The capture cycle sits inside the guard band, so it is always dark and needs no bypass.
      if (frame_edge) begin
        data_snap   <= bus.data_in;
        dp_snap     <= bus.dp_in;
        blank_snap  <= bus.blank_in;
        bright_snap <= bus.brightness;
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_multi.sv
// Directed bench for seg7_scan_multi: DIGITS=6, TICK_DIV=8, BRIGHT_W=2, GUARD=1.
// Outputs are sampled on the falling edge; expected digit codes are hand-computed.
module tb_seg7_scan_multi;
  localparam int DIGITS   = 6;
  localparam int BRIGHT_W = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  seg7_scan_multi_if #(.DIGITS(DIGITS), .BRIGHT_W(BRIGHT_W)) bus ();

  seg7_scan_multi #(
    .DIGITS(DIGITS), .CLK_HZ(8000), .SCAN_HZ(1000), .BRIGHT_W(BRIGHT_W), .GUARD(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_frame(input string tag);
    for (int i = 0; i < 200 && !bus.frame_start; i++) @(negedge clk);
    check({tag, "_sync"}, 48'(bus.frame_start), 48'd1);
  endtask

  // Checks one full 48-cycle frame; codes holds digit 0 in the top byte.
  task automatic check_frame(input string tag, input logic [47:0] codes, input int bright,
                             input bit chg, input logic [23:0] new_data);
    logic       lit;
    logic [7:0] exp_seg;
    wait_frame(tag);
    for (int s = 0; s < DIGITS; s++) begin
      for (int o = 0; o < 8; o++) begin
        if (chg && s == 2 && o == 0) bus.data_in = new_data;
        lit     = (o >= 1) && (bright == 3 || (o % 4) < bright);
        exp_seg = lit ? codes[47-8*s -: 8] : 8'hFF;
        check({tag, "_sel"}, 48'(bus.sel), 48'(s));
        check({tag, "_seg"}, 48'(bus.seg), 48'(exp_seg));
        check({tag, "_fs"}, 48'(bus.frame_start), 48'(s == 0 && o == 0));
        @(negedge clk);
      end
    end
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  initial begin
    rst            = 1'b1;
    bus.data_in    = 24'h123456;
    bus.dp_in      = '0;
    bus.blank_in   = '0;
    bus.brightness = 2'd3;
    repeat (2) @(negedge clk);
    check("rst_sel", 48'(bus.sel), 48'd0);
    check("rst_seg", 48'(bus.seg), 48'hFF);
    check("rst_fs", 48'(bus.frame_start), 48'd0);
    rst = 1'b0;
    @(negedge clk);
    check("first_fs", 48'(bus.frame_start), 48'd1);

    check_frame("scan", 48'hF9A4B0999282, 3, 1'b0, 24'h0);
    check_frame("scan2", 48'hF9A4B0999282, 3, 1'b0, 24'h0);

    check_frame("snap", 48'hF9A4B0999282, 3, 1'b1, 24'hABCDEF);
    check_frame("snap_next", 48'h8883C6A1868E, 3, 1'b0, 24'h0);

    bus.data_in    = 24'h123456;
    bus.brightness = 2'd1;
    settle();
    check_frame("bri1", 48'hF9A4B0999282, 1, 1'b0, 24'h0);
    bus.brightness = 2'd0;
    settle();
    check_frame("bri0", 48'hF9A4B0999282, 0, 1'b0, 24'h0);

    bus.brightness = 2'd3;
    bus.dp_in      = 6'b000001;
    bus.blank_in   = 6'b000010;
    settle();
    check_frame("dpblank", 48'h79FFB0999282, 3, 1'b0, 24'h0);

    bus.dp_in    = '0;
    bus.blank_in = '0;
    bus.data_in  = 24'h000120;
    settle();
`ifdef SEG7_LZ_BLANK_EN
    check_frame("lz", 48'hFFFFFFF9A4C0, 3, 1'b0, 24'h0);
`else
    check_frame("lz", 48'hC0C0C0F9A4C0, 3, 1'b0, 24'h0);
`endif
    bus.data_in = 24'h000000;
    settle();
`ifdef SEG7_LZ_BLANK_EN
    check_frame("lz0", 48'hFFFFFFFFFFC0, 3, 1'b0, 24'h0);
`else
    check_frame("lz0", 48'hC0C0C0C0C0C0, 3, 1'b0, 24'h0);
`endif

    bus.data_in = 24'h123456;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_sel", 48'(bus.sel), 48'd0);
      check("mid_rst_seg", 48'(bus.seg), 48'hFF);
      check("mid_rst_fs", 48'(bus.frame_start), 48'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("restart_fs", 48'(bus.frame_start), 48'd1);
    check("restart_sel", 48'(bus.sel), 48'd0);
    check_frame("restart", 48'hF9A4B0999282, 3, 1'b0, 24'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
